// File: rtl/cdc_src_clear_pkg.sv
// Shared types for the clearable CDC source-side buffer.
// No logic; holds the sequencer state encoding.
// Imported by the buffer top level.
package cdc_src_clear_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        CLEAR   = 2'd2,
        ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/cdc_src_clear_fifo.sv
// Small first-word-fall-through FIFO with a synchronous flush.
// Latency: a pushed word is visible on head the cycle after the push.
// Backpressure: the caller gates push with !full and pop with !empty.
module cdc_src_clear_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] usage,
    output T                           head
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign usage = count;
    assign head  = mem[rptr];

    // Storage; reset so the head output is defined straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wptr] <= data;
        end
    end

    // Pointer and occupancy tracking; flush drops contents but leaves mem alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= CW'(DEPTH));

endmodule

// File: rtl/cdc_src_clear_buffer.sv
// Buffers the producer stream ahead of a clearable CDC source and sequences its clear.
// Latency: one cycle from push to cdc_valid_o; a clear takes CLEAR_CYCLES+2 cycles.
// Backpressure: ready_o drops when the FIFO is full or any clear step is in progress.
module cdc_src_clear_buffer
    import cdc_src_clear_pkg::*;
#(
    parameter type         T            = logic,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_req_i,
    output logic                       clear_ack_o,
    output logic                       busy_o,
    input  T                           data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o,
    output T                           cdc_data_o,
    output logic                       cdc_valid_o,
    input  logic                       cdc_ready_i,
    output logic                       cdc_clear_o
);

    localparam int unsigned KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    state_t        state;
    logic [KW-1:0] clr_cnt;
    logic          idle;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          flush;

    // Stream is only open in IDLE, so the CDC never sees valid during its clear.
    assign idle        = (state == IDLE);
    assign ready_o     = idle && !full;
    assign cdc_valid_o = idle && !empty;
    assign push        = valid_i && ready_o;
    assign pop         = cdc_valid_o && cdc_ready_i;
    // Counter still holds its load value only on the first CLEAR cycle.
    assign flush       = (state == CLEAR) && (clr_cnt == KW'(CLEAR_CYCLES - 1));

    cdc_src_clear_fifo #(
        .T     (T),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .data   (data_i),
        .full   (full),
        .empty  (empty),
        .usage  (usage_o),
        .head   (cdc_data_o)
    );

    // Clear sequencer: isolate, hold clear for CLEAR_CYCLES, ack, with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            busy_o      <= 1'b0;
            cdc_clear_o <= 1'b0;
            clear_ack_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req_i) begin
                        state  <= ISOLATE;
                        busy_o <= 1'b1;
                    end
                end
                ISOLATE: begin
                    state       <= CLEAR;
                    cdc_clear_o <= 1'b1;
                    clr_cnt     <= KW'(CLEAR_CYCLES - 1);
                end
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        state       <= ACK;
                        cdc_clear_o <= 1'b0;
                        clear_ack_o <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt - KW'(1);
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    clear_ack_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    cdc_clear_o <= 1'b0;
                    clear_ack_o <= 1'b0;
                end
            endcase
        end
    end

    a_clear_excl_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cdc_clear_o |-> !cdc_valid_o);

endmodule
